// File: rtl/pci_initiator.sv
// ---------------------------------------------------------------------------
// pci_initiator
//
// Bus-master end of the simplified PCI interface. Accepts one burst command
// from local logic, runs a one-cycle address phase, then 1-4 data phases
// using the Frame/IRDY versus DEVSEL/TRDY handshake. Read beats are returned
// on a local stream. A target that never claims the cycle is dropped by a
// master abort after DEVSEL_TIMEOUT data-phase cycles.
//
// Optional feature (macro PCI_INIT_STALL_EN):
//   adds input local_stall. While it is high in DATA, the initiator inserts
//   wait states (IRDY = 1) and holds Frame/AD/CBE.
//
// Ports:
//   clk, RST             clock, synchronous active-high reset
//   cmd_valid/cmd_ready  local command handshake (ready only in IDLE)
//   cmd_write            1 = write burst, 0 = read burst
//   cmd_addr             address driven in the address phase
//   cmd_len              beats minus one
//   cmd_be               byte enables driven on CBE in every data phase
//   cmd_wdata            four write words, beat i in bits [32i+31:32i]
//   Frame, IRDY          active-low PCI controls, 1 when idle
//   CBE                  command / byte enables, Z when idle
//   AD                   multiplexed address/data, driven in ADDR and write DATA
//   DEVSEL, TRDY         active-low target responses
//   rd_valid/rd_data/rd_index  read beat stream (one-cycle valid pulse)
//   done                 one-cycle pulse on normal burst completion
//   err                  one-cycle pulse on master abort
// ---------------------------------------------------------------------------
module pci_initiator #(
    parameter int unsigned DEVSEL_TIMEOUT = 4,
    parameter logic [3:0]  PCI_read       = 4'b0010,
    parameter logic [3:0]  PCI_write      = 4'b0011
) (
    input  logic         clk,
    input  logic         RST,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic         cmd_write,
    input  logic [31:0]  cmd_addr,
    input  logic [1:0]   cmd_len,
    input  logic [3:0]   cmd_be,
    input  logic [127:0] cmd_wdata,
    output logic         Frame,
    output logic         IRDY,
    output logic [3:0]   CBE,
    inout  wire  [31:0]  AD,
    input  logic         DEVSEL,
    input  logic         TRDY,
`ifdef PCI_INIT_STALL_EN
    input  logic         local_stall,
`endif
    output logic         rd_valid,
    output logic [31:0]  rd_data,
    output logic [1:0]   rd_index,
    output logic         done,
    output logic         err
);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_TURN, S_ABORT} state_t;

    state_t        r_state, w_next_state;

    // Burst context
    logic [2:0]    r_rem, w_rem_n;      // beats still to transfer (0..4)
    logic [1:0]    r_idx, w_idx_n;      // current beat number
    logic          r_write;
    logic [3:0]    r_be;
    logic [127:0]  r_buf;
    logic [3:0]    r_tmo;               // data-phase cycles seen with DEVSEL high

    // Registered bus / stream outputs and their next values
    logic          r_frame, w_frame_n;
    logic          r_irdy, w_irdy_n;
    logic          r_cbe_oe, w_cbe_oe_n;
    logic [3:0]    r_cbe, w_cbe_n;
    logic          r_ad_oe, w_ad_oe_n;
    logic [31:0]   r_ad, w_ad_n;
    logic          r_cmd_ready, w_cmd_ready_n;
    logic          r_rd_valid, w_rd_valid_n;
    logic [31:0]   r_rd_data;
    logic [1:0]    r_rd_index;
    logic          r_done, w_done_n;
    logic          r_err, w_err_n;

    logic          w_stall;
    logic          w_accept;
    logic          w_xfer;
    logic          w_timeout;

`ifdef PCI_INIT_STALL_EN
    assign w_stall = local_stall;
`else
    assign w_stall = 1'b0;
`endif

    assign w_accept  = (r_state == S_IDLE) && cmd_valid;
    // TRDY only counts once the target has claimed the cycle with DEVSEL.
    assign w_xfer    = (r_state == S_DATA) && !r_irdy && !DEVSEL && !TRDY;
    assign w_timeout = (r_state == S_DATA) && DEVSEL &&
                       (r_tmo == 4'(DEVSEL_TIMEOUT - 1));

    // ---------------- state register ----------------
    // NOTE: every clocked block uses non-blocking assignments so all flops
    // sample the same pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    // ---------------- next-state logic ----------------
    // NOTE: each always_comb output gets a default assignment first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next_state = S_ADDR;
            S_ADDR:  w_next_state = S_DATA;
            S_DATA: begin
                if (w_xfer && (r_rem == 3'd1)) w_next_state = S_TURN;
                else if (w_timeout)            w_next_state = S_ABORT;
            end
            S_TURN:  w_next_state = S_IDLE;
            S_ABORT: w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // ---------------- burst context ----------------
    always_comb begin
        w_rem_n = r_rem;
        w_idx_n = r_idx;
        if (w_accept) begin
            w_rem_n = {1'b0, cmd_len} + 3'd1;
            w_idx_n = 2'd0;
        end else if (w_xfer) begin
            w_rem_n = r_rem - 3'd1;
            w_idx_n = r_idx + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            r_rem   <= 3'd0;
            r_idx   <= 2'd0;
            r_write <= 1'b0;
            r_be    <= 4'd0;
            r_tmo   <= 4'd0;
        end else begin
            r_rem <= w_rem_n;
            r_idx <= w_idx_n;
            if (w_accept) begin
                r_write <= cmd_write;
                r_be    <= cmd_be;
            end
            if (r_state == S_ADDR)
                r_tmo <= 4'd0;
            else if ((r_state == S_DATA) && DEVSEL)
                r_tmo <= r_tmo + 4'd1;
        end
    end

    // NOTE: the write buffer is pure data, only read after a command has
    // loaded it, so it is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_accept) r_buf <= cmd_wdata;
    end

    // ---------------- output logic ----------------
    // Outputs are computed from the next state and next context so that the
    // registered values line up with the state they belong to.
    always_comb begin
        w_frame_n     = 1'b1;
        w_irdy_n      = 1'b1;
        w_cbe_oe_n    = 1'b0;
        w_cbe_n       = r_cbe;
        w_ad_oe_n     = 1'b0;
        w_ad_n        = r_ad;
        w_cmd_ready_n = (w_next_state == S_IDLE);
        w_rd_valid_n  = w_xfer && !r_write;
        w_done_n      = (w_next_state == S_TURN);
        w_err_n       = (w_next_state == S_ABORT);
        case (w_next_state)
            S_ADDR: begin
                w_frame_n  = 1'b0;
                w_cbe_oe_n = 1'b1;
                w_cbe_n    = cmd_write ? PCI_write : PCI_read;
                w_ad_oe_n  = 1'b1;
                w_ad_n     = cmd_addr;
            end
            S_DATA: begin
                // Frame deasserts for the final data phase.
                w_frame_n  = (w_rem_n == 3'd1);
                w_irdy_n   = w_stall;
                w_cbe_oe_n = 1'b1;
                w_cbe_n    = r_be;
                w_ad_oe_n  = r_write;
                w_ad_n     = r_write ? r_buf[{w_idx_n, 5'd0} +: 32] : r_ad;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            r_frame     <= 1'b1;
            r_irdy      <= 1'b1;
            r_cbe_oe    <= 1'b0;
            r_cbe       <= 4'd0;
            r_ad_oe     <= 1'b0;
            r_ad        <= 32'd0;
            r_cmd_ready <= 1'b1;
            r_rd_valid  <= 1'b0;
            r_rd_data   <= 32'd0;
            r_rd_index  <= 2'd0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_frame     <= w_frame_n;
            r_irdy      <= w_irdy_n;
            r_cbe_oe    <= w_cbe_oe_n;
            r_cbe       <= w_cbe_n;
            r_ad_oe     <= w_ad_oe_n;
            r_ad        <= w_ad_n;
            r_cmd_ready <= w_cmd_ready_n;
            r_rd_valid  <= w_rd_valid_n;
            r_done      <= w_done_n;
            r_err       <= w_err_n;
            if (w_rd_valid_n) begin
                r_rd_data  <= AD;
                r_rd_index <= r_idx;
            end
        end
    end

    assign Frame     = r_frame;
    assign IRDY      = r_irdy;
    assign CBE       = r_cbe_oe ? r_cbe : 4'bz;
    assign AD        = r_ad_oe  ? r_ad  : 32'bz;
    assign cmd_ready = r_cmd_ready;
    assign rd_valid  = r_rd_valid;
    assign rd_data   = r_rd_data;
    assign rd_index  = r_rd_index;
    assign done      = r_done;
    assign err       = r_err;

endmodule

// File: tb/tb_pci_initiator.sv
// ---------------------------------------------------------------------------
// tb_pci_initiator
//
// Directed bench for pci_initiator: reset, 4-beat write, 3-beat read with
// target wait states, master abort, reset mid-burst and (with
// PCI_INIT_STALL_EN) an initiator stall. The bench plays the PCI target and
// drives AD itself during read data phases.
// ---------------------------------------------------------------------------
module tb_pci_initiator;

    logic         clk = 1'b0;
    logic         RST;
    logic         cmd_valid;
    logic         cmd_ready;
    logic         cmd_write;
    logic [31:0]  cmd_addr;
    logic [1:0]   cmd_len;
    logic [3:0]   cmd_be;
    logic [127:0] cmd_wdata;
    logic         Frame;
    logic         IRDY;
    logic [3:0]   CBE;
    wire  [31:0]  AD;
    logic         DEVSEL;
    logic         TRDY;
    logic         rd_valid;
    logic [31:0]  rd_data;
    logic [1:0]   rd_index;
    logic         done;
    logic         err;
`ifdef PCI_INIT_STALL_EN
    logic         local_stall;
`endif

    // Target-side AD driver
    logic         tb_ad_oe;
    logic [31:0]  tb_ad;
    assign AD = tb_ad_oe ? tb_ad : 32'bz;

    int checks   = 0;
    int failures = 0;

    pci_initiator dut (
        .clk        (clk),
        .RST        (RST),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
        .cmd_be     (cmd_be),
        .cmd_wdata  (cmd_wdata),
        .Frame      (Frame),
        .IRDY       (IRDY),
        .CBE        (CBE),
        .AD         (AD),
        .DEVSEL     (DEVSEL),
        .TRDY       (TRDY),
`ifdef PCI_INIT_STALL_EN
        .local_stall(local_stall),
`endif
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_index   (rd_index),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle past the active edge before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        RST       = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 32'd0;
        cmd_len   = 2'd0;
        cmd_be    = 4'd0;
        cmd_wdata = 128'd0;
        DEVSEL    = 1'b1;
        TRDY      = 1'b1;
        tb_ad_oe  = 1'b0;
        tb_ad     = 32'd0;
`ifdef PCI_INIT_STALL_EN
        local_stall = 1'b0;
`endif

        // ---------------- reset ----------------
        tick(); tick(); tick();
        check("rst_frame",    Frame, 1);
        check("rst_irdy",     IRDY, 1);
        check("rst_cbe_oe",   dut.r_cbe_oe, 0);
        check("rst_ad_oe",    dut.r_ad_oe, 0);
        check("rst_ready",    cmd_ready, 1);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_done",     done, 0);
        check("rst_err",      err, 0);
        RST = 1'b0;
        tick();

        // ---------------- 4-beat write, zero-wait target ----------------
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h10;
        cmd_len   = 2'd3;
        cmd_be    = 4'b1111;
        cmd_wdata = {32'h1004, 32'h1003, 32'h1002, 32'h1001};
        tick();                                  // accept edge, now ADDR
        check("wr_addr_ad",    AD, 32'h10);
        check("wr_addr_cbe",   CBE, 4'b0011);
        check("wr_addr_frame", Frame, 0);
        check("wr_addr_irdy",  IRDY, 1);
        check("wr_addr_ready", cmd_ready, 0);
        cmd_valid = 1'b0;
        DEVSEL    = 1'b0;
        TRDY      = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();                              // beat i on the bus
            check("wr_data_ad",    AD, 32'h1001 + 32'(i));
            check("wr_data_frame", Frame, (i == 3) ? 1 : 0);
            check("wr_data_irdy",  IRDY, 0);
            check("wr_data_cbe",   CBE, 4'b1111);
            check("wr_data_done",  done, 0);
        end
        tick();                                  // last transfer taken, TURN
        check("wr_done",       done, 1);
        check("wr_turn_frame", Frame, 1);
        check("wr_turn_irdy",  IRDY, 1);
        check("wr_turn_ad_oe", dut.r_ad_oe, 0);
        check("wr_turn_ready", cmd_ready, 0);
        DEVSEL = 1'b1;
        TRDY   = 1'b1;
        tick();                                  // IDLE
        check("wr_done_clr",   done, 0);
        check("wr_idle_ready", cmd_ready, 1);

        // ---------------- 3-beat read, 2 wait states ----------------
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h20;
        cmd_len   = 2'd2;
        tick();                                  // ADDR
        check("rd_addr_cbe", CBE, 4'b0010);
        check("rd_addr_ad",  AD, 32'h20);
        cmd_valid = 1'b0;
        DEVSEL    = 1'b0;
        tick();                                  // DATA, bus turned around
        check("rd_data_ad_oe", dut.r_ad_oe, 0);
        check("rd_data_irdy",  IRDY, 0);
        tb_ad_oe = 1'b1;
        tb_ad    = 32'd7;
        for (int w = 0; w < 2; w++) begin
            tick();                              // wait state
            check("rd_wait_valid", rd_valid, 0);
            check("rd_wait_ad_oe", dut.r_ad_oe, 0);
            check("rd_wait_irdy",  IRDY, 0);
        end
        TRDY = 1'b0;
        for (int b = 0; b < 3; b++) begin
            tick();                              // beat b transferred
            check("rd_valid", rd_valid, 1);
            check("rd_index", rd_index, 32'(b));
            check("rd_data",  rd_data, 32'd7 + 32'(b));
            check("rd_ad_oe", dut.r_ad_oe, 0);
            check("rd_done",  done, (b == 2) ? 1 : 0);
            tb_ad = 32'd8 + 32'(b);
        end
        tb_ad_oe = 1'b0;
        TRDY     = 1'b1;
        DEVSEL   = 1'b1;
        tick();                                  // IDLE
        check("rd_valid_end", rd_valid, 0);
        check("rd_idle_ready", cmd_ready, 1);

        // ---------------- master abort ----------------
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h30;
        cmd_len   = 2'd3;
        tick();                                  // ADDR
        cmd_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("ab_err_early", err, 0);
            check("ab_done",      done, 0);
        end
        tick();                                  // 5 cycles after ADDR
        check("ab_err",      err, 1);
        check("ab_done_end", done, 0);
        check("ab_frame",    Frame, 1);
        check("ab_irdy",     IRDY, 1);
        check("ab_ad_oe",    dut.r_ad_oe, 0);
        check("ab_cbe_oe",   dut.r_cbe_oe, 0);
        check("ab_ready",    cmd_ready, 0);
        check("ab_rd_valid", rd_valid, 0);
        tick();
        check("ab_err_clr",   err, 0);
        check("ab_ready_end", cmd_ready, 1);

        // ---------------- reset mid-burst ----------------
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h40;
        cmd_len   = 2'd3;
        tick();                                  // ADDR
        cmd_valid = 1'b0;
        DEVSEL    = 1'b0;
        TRDY      = 1'b0;
        tick();                                  // first data phase
        tb_ad_oe = 1'b1;
        tb_ad    = 32'hA0;
        tick();                                  // beat 0 taken, second phase
        check("mr_valid0", rd_valid, 1);
        check("mr_data0",  rd_data, 32'hA0);
        tb_ad = 32'hA1;
        RST   = 1'b1;
        tick();                                  // reset wins over transfer
        check("mr_frame",    Frame, 1);
        check("mr_irdy",     IRDY, 1);
        check("mr_rd_valid", rd_valid, 0);
        check("mr_done",     done, 0);
        check("mr_err",      err, 0);
        check("mr_ready",    cmd_ready, 1);
        check("mr_ad_oe",    dut.r_ad_oe, 0);
        RST      = 1'b0;
        tb_ad_oe = 1'b0;
        DEVSEL   = 1'b1;
        TRDY     = 1'b1;
        tick();
        check("mr_rd_valid2", rd_valid, 0);
        check("mr_done2",     done, 0);
        check("mr_err2",      err, 0);

`ifdef PCI_INIT_STALL_EN
        // ---------------- initiator stall ----------------
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h50;
        cmd_len   = 2'd3;
        cmd_wdata = {32'h1004, 32'h1003, 32'h1002, 32'h1001};
        tick();                                  // ADDR
        cmd_valid = 1'b0;
        DEVSEL    = 1'b0;
        TRDY      = 1'b0;
        tick();                                  // beat 0 on bus
        tick();                                  // beat 0 taken, beat 1 on bus
        check("st_ad_b1", AD, 32'h1002);
        local_stall = 1'b1;
        tick();                                  // beat 1 taken, stall seen
        check("st_irdy0", IRDY, 1);
        check("st_ad0",   AD, 32'h1003);
        tick();                                  // second stall cycle
        check("st_irdy1", IRDY, 1);
        check("st_ad1",   AD, 32'h1003);
        check("st_frame", Frame, 0);
        local_stall = 1'b0;
        tick();                                  // stall over, no transfer yet
        check("st_irdy2", IRDY, 0);
        check("st_ad2",   AD, 32'h1003);
        tick();                                  // beat 2 taken
        check("st_ad3",    AD, 32'h1004);
        check("st_frame3", Frame, 1);
        tick();                                  // beat 3 taken
        check("st_done", done, 1);
        DEVSEL = 1'b1;
        TRDY   = 1'b1;
        tick();
        check("st_done_clr", done, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
